// File: rtl/lspc_host_master.sv
// lspc_host_master: 68k-style bus master driving the LSPC2 CPU register port.
// Latency: single ops complete STROBE_CYCLES+3 cycles after acceptance; NOP on the next cycle.
// Backpressure: CMD_READY is high only in IDLE; optional VRAM fill bursts compiled in with LSPC_BURST_EN.
module lspc_host_master #(
    parameter int STROBE_CYCLES = 8
) (
    input  logic        CLK_24M,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_OP,
    input  logic [2:0]  CMD_REG,
    input  logic [15:0] CMD_DATA,
    input  logic [15:0] CMD_ADDR,
    input  logic [15:0] CMD_MOD,
    input  logic [15:0] CMD_COUNT,
    output logic [2:0]  M68K_ADDR,
    output logic [15:0] M68K_DATA_OUT,
    output logic        M68K_DATA_OE,
    input  logic [15:0] M68K_DATA_IN,
    output logic        LSPWE,
    output logic        LSPOE,
    output logic        RSP_VALID,
    output logic [15:0] RSP_DATA
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;

    localparam logic [7:0] STRB_LAST = 8'(STROBE_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [7:0]  strb_cnt;
    logic        is_read;
    logic [2:0]  reg_q;
    logic [15:0] data_q;
    logic        rsp_vld_q;
    logic [15:0] rsp_data_q;

    logic        accept;
    logic        start_bus;
    logic        last_cycle;
    logic [2:0]  cur_reg;
    logic [15:0] cur_data;

    // Ready is purely state based; reset holds it low without waiting for an edge.
    assign CMD_READY = (state == S_IDLE) && !RESET;
    assign accept    = CMD_VALID && CMD_READY;

`ifdef LSPC_BURST_EN
    localparam logic [1:0] B_ADDR = 2'd0;
    localparam logic [1:0] B_MOD  = 2'd1;
    localparam logic [1:0] B_DATA = 2'd2;

    logic        burst_q;
    logic [1:0]  phase_q;
    logic [15:0] addr_q;
    logic [15:0] mod_q;
    logic [15:0] cnt_q;

    assign start_bus = (CMD_OP != 2'b11);

    // A burst ends after the VRAMMOD write when the count is zero, otherwise after the last data write.
    assign last_cycle = !burst_q
                     || ((phase_q == B_MOD)  && (cnt_q == 16'd0))
                     || ((phase_q == B_DATA) && (cnt_q == 16'd1));

    // Select which register/value the current bus cycle carries.
    always_comb begin
        cur_reg  = reg_q;
        cur_data = data_q;
        if (burst_q) begin
            case (phase_q)
                B_ADDR:  begin cur_reg = 3'd0; cur_data = addr_q; end
                B_MOD:   begin cur_reg = 3'd2; cur_data = mod_q;  end
                default: begin cur_reg = 3'd1; cur_data = data_q; end
            endcase
        end
    end

    // Burst bookkeeping: capture on acceptance, advance phase at the end of each HOLD.
    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            burst_q <= 1'b0;
            phase_q <= B_ADDR;
            addr_q  <= 16'd0;
            mod_q   <= 16'd0;
            cnt_q   <= 16'd0;
        end else if (accept) begin
            burst_q <= (CMD_OP == 2'b10);
            phase_q <= B_ADDR;
            addr_q  <= CMD_ADDR;
            mod_q   <= CMD_MOD;
            cnt_q   <= CMD_COUNT;
        end else if (state == S_HOLD && burst_q) begin
            case (phase_q)
                B_ADDR:  phase_q <= B_MOD;
                B_MOD:   phase_q <= B_DATA;
                default: cnt_q   <= cnt_q - 16'd1;
            endcase
        end
    end
`else
    logic unused_burst_inputs;
    assign unused_burst_inputs = ^{CMD_ADDR, CMD_MOD, CMD_COUNT};

    // Without burst support op 10 behaves like a NOP.
    assign start_bus  = !CMD_OP[1];
    assign last_cycle = 1'b1;
    assign cur_reg    = reg_q;
    assign cur_data   = data_q;
`endif

    // State register.
    always_ff @(posedge CLK_24M) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic for the bus-cycle sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept && start_bus) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_STROBE;
            S_STROBE: if (strb_cnt == 8'd0) state_nxt = S_HOLD;
            S_HOLD:   state_nxt = last_cycle ? S_IDLE : S_GAP;
            S_GAP:    state_nxt = S_SETUP;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from state so reset forces them idle on the same edge.
    always_comb begin
        M68K_ADDR     = 3'd0;
        M68K_DATA_OUT = 16'd0;
        M68K_DATA_OE  = 1'b0;
        LSPWE         = 1'b1;
        LSPOE         = 1'b1;
        case (state)
            S_SETUP, S_HOLD: begin
                M68K_ADDR     = cur_reg;
                M68K_DATA_OUT = cur_data;
                M68K_DATA_OE  = !is_read;
            end
            S_STROBE: begin
                M68K_ADDR     = cur_reg;
                M68K_DATA_OUT = cur_data;
                M68K_DATA_OE  = !is_read;
                LSPWE         = is_read;
                LSPOE         = !is_read;
            end
            default: ;
        endcase
    end

    // Strobe width counter, loaded during SETUP and counted down through STROBE.
    always_ff @(posedge CLK_24M) begin
        if (RESET)                   strb_cnt <= 8'd0;
        else if (state == S_SETUP)   strb_cnt <= STRB_LAST;
        else if (state == S_STROBE)  strb_cnt <= strb_cnt - 8'd1;
    end

    // Command capture and response generation.
    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            is_read    <= 1'b0;
            reg_q      <= 3'd0;
            data_q     <= 16'd0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= 16'd0;
        end else begin
            rsp_vld_q <= 1'b0;
            if (accept) begin
                is_read    <= (CMD_OP == 2'b01);
                reg_q      <= CMD_REG;
                data_q     <= CMD_DATA;
                rsp_data_q <= 16'd0;
                if (!start_bus) rsp_vld_q <= 1'b1;
            end
            if (state == S_STROBE && strb_cnt == 8'd0 && is_read)
                rsp_data_q <= M68K_DATA_IN;
            if (state == S_HOLD && last_cycle)
                rsp_vld_q <= 1'b1;
        end
    end

    assign RSP_VALID = rsp_vld_q;
    assign RSP_DATA  = rsp_data_q;

endmodule
